// File: rtl/safety_island_periph_demux.sv
// Address-map-driven demux from the safety island peripheral port to NumPorts targets.
// One transaction in flight, error response on unmapped addresses, per-transaction timeout.
module safety_island_periph_demux #(
  parameter int unsigned          NumPorts      = 10,
  parameter int unsigned          NumRules      = 10,
  parameter int unsigned          AddrWidth     = 32,
  parameter int unsigned          DataWidth     = 32,
  parameter int unsigned          TimeoutCycles = 1024,
  parameter logic [DataWidth-1:0] ErrData       = DataWidth'(32'hBADC_AB1E)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumRules*3*32-1:0]      addr_map_i,
  input  logic                          default_en_i,
  input  logic [31:0]                   default_idx_i,
  input  logic                          req_i,
  input  logic [AddrWidth-1:0]          addr_i,
  input  logic                          we_i,
  input  logic [DataWidth-1:0]          wdata_i,
  input  logic [DataWidth/8-1:0]        be_i,
  output logic                          gnt_o,
  output logic                          rvalid_o,
  output logic [DataWidth-1:0]          rdata_o,
  output logic                          err_o,
  output logic [NumPorts-1:0]           port_req_o,
  output logic [AddrWidth-1:0]          port_addr_o,
  output logic                          port_we_o,
  output logic [DataWidth-1:0]          port_wdata_o,
  output logic [DataWidth/8-1:0]        port_be_o,
  input  logic [NumPorts-1:0]           port_gnt_i,
  input  logic [NumPorts-1:0]           port_rvalid_i,
  input  logic [NumPorts*DataWidth-1:0] port_rdata_i,
  input  logic [NumPorts-1:0]           port_err_i,
  output logic                          timeout_o,
  output logic                          timeout_sticky_o,
  output logic [31:0]                   timeout_idx_o,
  input  logic                          timeout_clr_i,
  output logic [1:0]                    dbg_state_o
);

  localparam int unsigned     SelW    = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned     CntW    = $clog2(TimeoutCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
  localparam int unsigned     BeW     = DataWidth / 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FWD  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  // Upstream handshake: a request is accepted in any cycle where req_i and gnt_o
  // are both high; exactly one rvalid_o pulse answers each accepted request.
  logic [1:0]           state_q, state_d;
  logic [SelW-1:0]      sel_q, sel_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 we_q, we_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [BeW-1:0]       be_q, be_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 tmo_q, tmo_d;
  logic                 sticky_q, sticky_d;
  logic [31:0]          tidx_q, tidx_d;

  logic [31:0]          rule_idx, rule_start, rule_end;
  logic [63:0]          addr_ext;
  logic                 win_hit, route_ok;
  logic [31:0]          win_idx;
  logic [SelW-1:0]      route_sel;
  logic                 gnt;

  // Walk rules from highest to lowest so the lowest-numbered hit overwrites.
  always_comb begin
    addr_ext   = 64'(addr_i);
    win_hit    = 1'b0;
    win_idx    = '0;
    rule_idx   = '0;
    rule_start = '0;
    rule_end   = '0;
    for (int r = int'(NumRules) - 1; r >= 0; r--) begin
      rule_idx   = addr_map_i[r*96+64 +: 32];
      rule_start = addr_map_i[r*96+32 +: 32];
      rule_end   = addr_map_i[r*96    +: 32];
      if ((rule_start < rule_end) && (addr_ext >= 64'(rule_start)) &&
          (addr_ext < 64'(rule_end))) begin
        win_hit = 1'b1;
        win_idx = rule_idx;
      end
    end
    route_ok  = 1'b0;
    route_sel = '0;
    if (win_hit && (win_idx < 32'(NumPorts))) begin
      route_ok  = 1'b1;
      route_sel = SelW'(win_idx);
    end else if (default_en_i && (default_idx_i < 32'(NumPorts))) begin
      route_ok  = 1'b1;
      route_sel = SelW'(default_idx_i);
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    tmo_d    = 1'b0;
    sticky_d = sticky_q & ~timeout_clr_i;
    tidx_d   = tidx_q;
    gnt      = 1'b0;
    case (state_q)
      IDLE: begin
        gnt = req_i;
        if (req_i) begin
          addr_d  = addr_i;
          we_d    = we_i;
          wdata_d = wdata_i;
          be_d    = be_i;
          cnt_d   = '0;
          if (route_ok) begin
            sel_d   = route_sel;
            state_d = FWD;
          end else begin
            rdata_d = ErrData;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      FWD, WAIT: begin
        cnt_d = cnt_q + CntW'(1);
        if (state_q == FWD && port_gnt_i[sel_q]) begin
          if (port_rvalid_i[sel_q]) begin
            rdata_d = port_rdata_i[sel_q*DataWidth +: DataWidth];
            err_d   = port_err_i[sel_q];
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end else if (state_q == WAIT && port_rvalid_i[sel_q]) begin
          rdata_d = port_rdata_i[sel_q*DataWidth +: DataWidth];
          err_d   = port_err_i[sel_q];
          state_d = RESP;
        end else if (cnt_q == CntLast) begin
          // Abort: the stuck port is reported, and set beats a concurrent clear.
          rdata_d  = ErrData;
          err_d    = 1'b1;
          tmo_d    = 1'b1;
          sticky_d = 1'b1;
          tidx_d   = 32'(sel_q);
          state_d  = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      tmo_q    <= 1'b0;
      sticky_q <= 1'b0;
      tidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      sticky_q <= sticky_d;
      tidx_q   <= tidx_d;
    end
  end

  always_comb begin
    port_req_o = '0;
    if (state_q == FWD) port_req_o[sel_q] = 1'b1;
  end

  assign gnt_o            = gnt & rst_ni;
  assign rvalid_o         = (state_q == RESP);
  assign rdata_o          = rdata_q;
  assign err_o            = err_q;
  assign port_addr_o      = addr_q;
  assign port_we_o        = we_q;
  assign port_wdata_o     = wdata_q;
  assign port_be_o        = be_q;
  assign timeout_o        = tmo_q;
  assign timeout_sticky_o = sticky_q;
  assign timeout_idx_o    = tidx_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_safety_island_periph_demux.sv
// Directed bench for safety_island_periph_demux: queue scoreboard with a negedge response monitor.
module tb_safety_island_periph_demux;
  localparam int NP = 10;
  localparam int NR = 4;
  localparam logic [31:0] ERR_DATA = 32'hBADC_AB1E;

  logic clk, rst_ni;
  logic [NR*96-1:0] addr_map_i;
  logic default_en_i;
  logic [31:0] default_idx_i;
  logic req_i, we_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0] be_i;
  logic gnt_o, rvalid_o, err_o;
  logic [31:0] rdata_o;
  logic [NP-1:0] port_req_o;
  logic [31:0] port_addr_o, port_wdata_o;
  logic port_we_o;
  logic [3:0] port_be_o;
  logic [NP-1:0] port_gnt_i, port_rvalid_i, port_err_i;
  logic [NP*32-1:0] port_rdata_i;
  logic timeout_o, timeout_sticky_o, timeout_clr_i;
  logic [31:0] timeout_idx_o;
  logic [1:0] dbg_state_o;

  int checks = 0;
  int failures = 0;
  int resp_cnt = 0;
  logic [32:0] exp_q[$];

  safety_island_periph_demux #(
    .NumPorts(NP), .NumRules(NR), .AddrWidth(32), .DataWidth(32), .TimeoutCycles(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .addr_map_i(addr_map_i), .default_en_i(default_en_i),
    .default_idx_i(default_idx_i), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .port_req_o(port_req_o), .port_addr_o(port_addr_o), .port_we_o(port_we_o),
    .port_wdata_o(port_wdata_o), .port_be_o(port_be_o), .port_gnt_i(port_gnt_i),
    .port_rvalid_i(port_rvalid_i), .port_rdata_i(port_rdata_i), .port_err_i(port_err_i),
    .timeout_o(timeout_o), .timeout_sticky_o(timeout_sticky_o), .timeout_idx_o(timeout_idx_o),
    .timeout_clr_i(timeout_clr_i), .dbg_state_o(dbg_state_o)
  );

  // Clock and global watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard monitor: every upstream response pops one expected {err, rdata}
  always @(negedge clk) begin
    if (rst_ni && rvalid_o) begin
      resp_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_resp actual=err%0b/%08h required=no_response", err_o, rdata_o);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({err_o, rdata_o} !== e)
          begin
            failures++;
            $display("FAIL resp_data actual=err%0b/%08h required=err%0b/%08h",
                     err_o, rdata_o, e[32], e[31:0]);
          end
      end
    end
  end

  function automatic logic [95:0] rule(input logic [31:0] idx, input logic [31:0] s,
                                       input logic [31:0] e);
    return {idx, s, e};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_ports();
    port_gnt_i = '0;
    port_rvalid_i = '0;
    port_err_i = '0;
    port_rdata_i = '0;
  endtask

  task automatic wait_resp(input int n);
    for (int i = 0; i < 10 && resp_cnt == n; i++) begin
      @(negedge clk);
      #1;
    end
    chk("resp_seen", 64'(resp_cnt - n), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic hit_txn(input logic [31:0] addr, input int port, input logic we,
                         input logic [31:0] wdata, input logic [3:0] be, input int gnt_dly,
                         input int rv_dly, input logic [31:0] rdata, input logic perr);
    int n;
    logic [NP-1:0] oh;
    n = resp_cnt;
    oh = NP'(1) << port;
    exp_q.push_back({perr, rdata});
    req_i = 1'b1; addr_i = addr; we_i = we; wdata_i = wdata; be_i = be;
    @(negedge clk);
    chk("hit_gnt", 64'(gnt_o), 64'(1));
    @(posedge clk);
    #1;
    req_i = 1'b0; addr_i = ~addr; wdata_i = ~wdata; we_i = ~we; be_i = ~be;
    for (int c = 1; c <= rv_dly; c++) begin
      port_gnt_i = (c == gnt_dly) ? oh : '0;
      port_rvalid_i = (c == rv_dly) ? oh : '0;
      port_err_i = (c == rv_dly && perr) ? oh : '0;
      port_rdata_i = '0;
      port_rdata_i[port*32 +: 32] = (c == rv_dly) ? rdata : 32'hDEAD_0000;
      @(negedge clk);
      chk("hit_port_req", 64'(port_req_o), (c <= gnt_dly) ? 64'(oh) : 64'(0));
      if (c == 1)
        chk("hit_port_latch", {port_addr_o, port_wdata_o[26:0], port_we_o, port_be_o},
            {addr, wdata[26:0], we, be});
      @(posedge clk);
      #1;
    end
    clear_ports();
    wait_resp(n);
  endtask

  task automatic miss_txn(input logic [31:0] addr);
    int n;
    n = resp_cnt;
    exp_q.push_back({1'b1, ERR_DATA});
    req_i = 1'b1; addr_i = addr; we_i = 1'b0;
    @(negedge clk);
    chk("miss_gnt", 64'(gnt_o), 64'(1));
    @(posedge clk);
    #1;
    req_i = 1'b0;
    @(negedge clk);
    chk("miss_rvalid_next", 64'(rvalid_o), 64'(1));
    chk("miss_no_port_req", 64'(port_req_o), 64'(0));
    #1;
    wait_resp(n);
  endtask

  logic [NR*96-1:0] map_a, map_b;
  int n0;

  initial begin
    rst_ni = 1'b0; req_i = 1'b0; addr_i = '0; we_i = 1'b0; wdata_i = '0; be_i = '0;
    default_en_i = 1'b0; default_idx_i = '0; timeout_clr_i = 1'b0;
    clear_ports();
    map_a = {rule(4, 32'h3000, 32'h4000), rule(12, 32'h4_0000, 32'h5_0000),
             rule(2, 32'h1000, 32'h2000), rule(0, 32'h0, 32'h1000)};
    map_b = {rule(1, 32'h5000, 32'h4000), rule(7, 32'h2000, 32'h2000),
             rule(5, 32'h0, 32'h1000), rule(3, 32'h0, 32'h100)};
    addr_map_i = map_a;
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    @(negedge clk);
    chk("reset_upstream", {gnt_o, rvalid_o, err_o, rdata_o}, 64'(0));
    chk("reset_port", {port_req_o, port_addr_o, port_we_o}, 64'(0));
    chk("reset_timeout", {timeout_o, timeout_sticky_o, timeout_idx_o, dbg_state_o}, 64'(0));
    @(posedge clk);
    #1;

    // Basic routing, split and same-cycle grant/response
    hit_txn(32'h1004, 2, 1'b0, 32'h0, 4'hf, 1, 3, 32'h1234_5678, 1'b0);
    hit_txn(32'h0010, 0, 1'b1, 32'hCAFE_F00D, 4'b0011, 2, 2, 32'h0000_0001, 1'b0);
    hit_txn(32'h1FFC, 2, 1'b0, 32'h0, 4'hf, 1, 1, 32'hA5A5_0001, 1'b1);

    // Unmapped, invalid rule index, and default routing
    miss_txn(32'h0004_0000);
    miss_txn(32'h0000_2000);
    default_en_i = 1'b1; default_idx_i = 32'd0;
    hit_txn(32'h0004_0000, 0, 1'b0, 32'h0, 4'hf, 1, 2, 32'h0BAD_0002, 1'b0);
    default_idx_i = 32'd12;
    miss_txn(32'h0000_9000);
    default_en_i = 1'b0; default_idx_i = 32'd0;

    // Overlap priority and degenerate rules
    addr_map_i = map_b;
    hit_txn(32'h0080, 3, 1'b0, 32'h0, 4'hf, 1, 2, 32'h3333_0080, 1'b0);
    hit_txn(32'h0200, 5, 1'b0, 32'h0, 4'hf, 1, 2, 32'h5555_0200, 1'b0);
    miss_txn(32'h2000);
    miss_txn(32'h4800);
    addr_map_i = map_a;

    // Timeout on port 4
    n0 = resp_cnt;
    exp_q.push_back({1'b1, ERR_DATA});
    req_i = 1'b1; addr_i = 32'h3004;
    @(negedge clk);
    chk("tmo_gnt", 64'(gnt_o), 64'(1));
    @(posedge clk);
    #1;
    req_i = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      chk("tmo_port_req", 64'(port_req_o), 64'(NP'(1) << 4));
      chk("tmo_no_pulse_yet", 64'(timeout_o), 64'(0));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("tmo_abort", {port_req_o, rvalid_o, timeout_o, timeout_sticky_o},
        {10'b0, 1'b1, 1'b1, 1'b1});
    chk("tmo_idx", 64'(timeout_idx_o), 64'(4));
    #1;
    @(posedge clk);
    #1;
    port_gnt_i[4] = 1'b1; port_rvalid_i[4] = 1'b1; port_rdata_i[4*32 +: 32] = 32'h4444_4444;
    @(negedge clk);
    chk("tmo_pulse_once", 64'(timeout_o), 64'(0));
    chk("late_rvalid_ignored", 64'(rvalid_o), 64'(0));
    chk("sticky_held", 64'(timeout_sticky_o), 64'(1));
    @(posedge clk);
    #1;
    clear_ports();
    @(negedge clk);
    chk("late_no_resp", 64'(resp_cnt - n0), 64'(1));
    @(posedge clk);
    #1;
    timeout_clr_i = 1'b1;
    @(posedge clk);
    #1;
    timeout_clr_i = 1'b0;
    @(negedge clk);
    chk("sticky_cleared", {timeout_sticky_o, timeout_idx_o}, {1'b0, 32'd4});
    @(posedge clk);
    #1;

    // Reset while waiting for a response
    req_i = 1'b1; addr_i = 32'h1004;
    @(posedge clk);
    #1;
    req_i = 1'b0;
    port_gnt_i[2] = 1'b1;
    @(posedge clk);
    #1;
    port_gnt_i = '0;
    @(negedge clk);
    chk("wait_state", 64'(dbg_state_o), 64'(2));
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_mid_upstream", {gnt_o, rvalid_o, err_o, rdata_o}, 64'(0));
    chk("rst_mid_port", {port_req_o, timeout_o, timeout_sticky_o, timeout_idx_o}, 64'(0));
    @(posedge clk);
    #1;
    hit_txn(32'h1008, 2, 1'b0, 32'h0, 4'hf, 1, 3, 32'h2222_1008, 1'b0);

    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
